laser_target_controller: RTL and testbench
==========================================

# laser_target_controller

Parametrised game controller for the laser shooting arcade. It drives a bank of N target LEDs, picks each target pseudo-randomly, and detects hits on the matching active-low LDR channel using a consecutive-sample filter. It also tracks hits and misses over a fixed number of rounds. It sits between the board I/O (start button, LDR array, LED bank) and the score display logic. All timing advances on an external `tick` strobe, so no internal clock divider is needed.

## Interface
- `N_TGT`, 7: number of targets, LEDs and LDR channels (2..16)
- `ROUNDS`, 10: targets presented per game (1..255)
- `TGT_TICKS`, 50000: ticks a target stays lit before it counts as a miss
- `GAP_TICKS`, 1000: ticks with all LEDs dark between targets
- `OVER_TICKS`, 50000: ticks spent in game-over display
- `HIT_TICKS`, 4: consecutive dark LDR samples required for a hit (1..15)
- `SEED`, 8'hA5: LFSR reset value; 0 is replaced by 8'h01
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `tick`  in  1  one-`clk`-wide timebase strobe; all timers and sampling advance only on `tick`
- `start_btn`  in  1  start button, asynchronous, active-high
- `ldr_sensors`  in  N_TGT  LDR comparators, asynchronous; 0 = laser present
- `leds_r`  out  N_TGT  target LEDs, 1 = lit
- `score`  out  SW  hits this game, SW = $clog2(ROUNDS+1)
- `misses`  out  SW  timed-out targets this game
- `hit_pulse`  out  1  one-`clk` pulse on each registered hit
- `busy`  out  1  high in GAP and ACTIVE
- `game_over`  out  1  high in OVER

## Operation
- **Input synchronisation.** `start_btn` and each `ldr_sensors` bit pass through 2-FF synchronisers. A start is the rising edge of the synchronised button.
- **Random source.** An 8-bit Galois LFSR (mask 8'hB8) steps on every `clk`, not only on ticks, so target selection depends on press timing.
  - Candidate index = lfsr % N_TGT.
  - If the candidate equals the previous target, use (candidate+1) % N_TGT instead. This forbids back-to-back repeats.
  - The previous target is reset to N_TGT-1.
- **FSM states:**
  - IDLE: `leds_r` all ones. `score` and `misses` hold the last game's result. On a start: clear score, misses and round counter, then go to GAP.
  - GAP: `leds_r` all zero. After GAP_TICKS ticks, latch the target index and go to ACTIVE.
  - ACTIVE: `leds_r` one-hot at the target index.
    - On each tick: if the synchronised `ldr_sensors[idx]` is 0, increment the run counter; otherwise clear it.
    - When the run counter reaches HIT_TICKS, register a hit: score+1, pulse `hit_pulse`, round done.
    - If the timer expires first, register a miss: misses+1, round done.
    - On round done, increment the round counter. If it equals ROUNDS, go to OVER; otherwise go to GAP.
    - Light on non-target LDRs is ignored.
  - OVER: `leds_r` all ones, `game_over`=1. After OVER_TICKS ticks, go to IDLE.
- Start edges outside IDLE are ignored and are not queued.
- score + misses == ROUNDS at OVER entry. Neither counter can overflow SW bits.

## Timing
- **Reset values:** state IDLE, `leds_r` all ones, `score`=0, `misses`=0, `hit_pulse`=0, `busy`=0, `game_over`=0, lfsr=SEED (or 1), run counter=0, round counter=0.
- **Mid-game reset:** immediate return to IDLE with the above values. No partial score is kept.
- **Timers:** load count-1 on state entry, decrement on tick, expire on a tick while at 0. The state therefore lasts exactly GAP_TICKS, TGT_TICKS or OVER_TICKS ticks, and the transition occurs on the `clk` of the expiring tick.
- **Start latency:** `busy` rises 4 `clk` after `start_btn` rises (2 sync, 1 edge, 1 state register).
- **Sensor latency:** 2 `clk` from `ldr_sensors` to the sampled value.
- **Hit timing:** the hit registers on the tick of the HIT_TICKS-th consecutive dark sample. `score` and `hit_pulse` update on that same `clk` edge, and `leds_r` goes dark (GAP) on that edge.
- **Hit vs. timeout:** if hit and timer expiry fall on the same tick, the hit wins and misses is unchanged.
- **Run counter:** cleared on ACTIVE entry. A beam already on the target before it lights still needs HIT_TICKS ticks from entry.
- **`tick` low:** all timers, the run counter and the FSM hold. Only the LFSR and synchronisers advance.

## Test plan
Test plan parameters: N_TGT=4, ROUNDS=3, TGT_TICKS=8, GAP_TICKS=2, OVER_TICKS=4, HIT_TICKS=2, `tick` tied high.

- Reset, no start → `leds_r`=4'b1111, `score`=`misses`=0, `busy`=0 for 100 clk.
- Start, no light → 3 ACTIVE windows of exactly 8 clk, each one-hot and never repeating the previous index. Then `misses`=3, `score`=0, `game_over` high for 4 clk, then IDLE.
- Start, drive the target LDR low 2 clk after each ACTIVE entry → 3 `hit_pulse`, `score`=3, `misses`=0. A low of only 1 sample, then high, gives no hit.
- Hold the target LDR low so the 2nd dark sample lands on the timer's last tick → counted as a hit: `score`+1, `misses` unchanged.
- Assert `rst` mid-ACTIVE with `score`=1 → `leds_r`=1111 and `score`=0 asynchronously. Pressing start during GAP or OVER → no effect.
- Light on a non-target LDR for the whole window → miss counted, `score` unchanged.

Source files
------------

// File: rtl/laser_target_controller.sv
// Laser arcade game core: LFSR target pick, filtered LDR hit detection, per-game hit/miss tally.
// Start-to-busy 4 clk, sensor-to-sample 2 clk; timers, run filter and FSM advance only on tick.
module laser_target_controller #(
  parameter int          N_TGT      = 7,
  parameter int          ROUNDS     = 10,
  parameter int          TGT_TICKS  = 50000,
  parameter int          GAP_TICKS  = 1000,
  parameter int          OVER_TICKS = 50000,
  parameter int          HIT_TICKS  = 4,
  parameter logic [7:0]  SEED       = 8'hA5,
  localparam int         SW         = $clog2(ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start_btn,
  input  logic [N_TGT-1:0] ldr_sensors,
  output logic [N_TGT-1:0] leds_r,
  output logic [SW-1:0]    score,
  output logic [SW-1:0]    misses,
  output logic             hit_pulse,
  output logic             busy,
  output logic             game_over
);

  localparam int         IW        = $clog2(N_TGT);
  localparam int         MAXT_A    = (TGT_TICKS > GAP_TICKS) ? TGT_TICKS : GAP_TICKS;
  localparam int         MAXT      = (MAXT_A > OVER_TICKS) ? MAXT_A : OVER_TICKS;
  localparam int         TW        = $clog2(MAXT + 1);
  localparam logic [7:0] LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_ACTIVE, S_OVER} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [3:0]       run_q, run_d;
  logic [SW-1:0]    round_q, round_d;
  logic [SW-1:0]    score_q, score_d;
  logic [SW-1:0]    misses_q, misses_d;
  logic [IW-1:0]    tgt_q, tgt_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [2:0]       start_sync_q;
  logic             start_edge_q;
  logic [N_TGT-1:0] ldr_s1_q, ldr_s2_q;

  logic [IW-1:0]    cand, pick;
  logic             dark, round_done;

  // LFSR runs every clk so the chosen target depends on when the player pressed start
  assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  assign cand   = IW'(32'(lfsr_q) % N_TGT);
  assign pick   = (cand != tgt_q) ? cand :
                  (cand == IW'(N_TGT - 1)) ? '0 : cand + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync_q <= '0;
      start_edge_q <= 1'b0;
      ldr_s1_q     <= '1;
      ldr_s2_q     <= '1;
      lfsr_q       <= LFSR_INIT;
    end else begin
      start_sync_q <= {start_sync_q[1:0], start_btn};
      start_edge_q <= start_sync_q[1] & ~start_sync_q[2];
      ldr_s1_q     <= ldr_sensors;
      ldr_s2_q     <= ldr_s1_q;
      lfsr_q       <= lfsr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      run_q       <= '0;
      round_q     <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      tgt_q       <= IW'(N_TGT - 1);
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      run_q       <= run_d;
      round_q     <= round_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      tgt_q       <= tgt_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    run_d       = run_q;
    round_d     = round_q;
    score_d     = score_q;
    misses_d    = misses_q;
    tgt_d       = tgt_q;
    hit_pulse_d = 1'b0;
    dark        = ~ldr_s2_q[tgt_q];
    round_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge_q) begin
          score_d  = '0;
          misses_d = '0;
          round_d  = '0;
          timer_d  = TW'(GAP_TICKS - 1);
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) begin
          if (timer_q == '0) begin
            tgt_d   = pick;
            run_d   = '0;
            timer_d = TW'(TGT_TICKS - 1);
            state_d = S_ACTIVE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      S_ACTIVE: begin
        if (tick) begin
          // A hit on the expiring tick takes priority over the miss
          if (dark && run_q == 4'(HIT_TICKS - 1)) begin
            score_d     = score_q + SW'(1);
            hit_pulse_d = 1'b1;
            round_done  = 1'b1;
          end else if (timer_q == '0) begin
            misses_d   = misses_q + SW'(1);
            round_done = 1'b1;
          end else begin
            timer_d = timer_q - TW'(1);
            run_d   = dark ? run_q + 4'd1 : 4'd0;
          end
          if (round_done) begin
            round_d = round_q + SW'(1);
            if ({1'b0, round_q} + (SW + 1)'(1) == (SW + 1)'(ROUNDS)) begin
              timer_d = TW'(OVER_TICKS - 1);
              state_d = S_OVER;
            end else begin
              timer_d = TW'(GAP_TICKS - 1);
              state_d = S_GAP;
            end
          end
        end
      end
      S_OVER: begin
        if (tick) begin
          if (timer_q == '0) state_d = S_IDLE;
          else               timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    leds_r = '1;
    case (state_q)
      S_GAP:    leds_r = '0;
      S_ACTIVE: begin
        leds_r        = '0;
        leds_r[tgt_q] = 1'b1;
      end
      default:  leds_r = '1;
    endcase
  end

  assign score     = score_q;
  assign misses    = misses_q;
  assign hit_pulse = hit_pulse_q;
  assign busy      = (state_q == S_GAP) || (state_q == S_ACTIVE);
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_laser_target_controller.sv
// Directed bench for laser_target_controller with the small game configuration and tick tied high.
module tb_laser_target_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start_btn;
  logic [3:0] ldr_sensors;
  logic [3:0] leds_r;
  logic [1:0] score;
  logic [1:0] misses;
  logic       hit_pulse;
  logic       busy;
  logic       game_over;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  laser_target_controller #(
    .N_TGT(4), .ROUNDS(3), .TGT_TICKS(8), .GAP_TICKS(2),
    .OVER_TICKS(4), .HIT_TICKS(2), .SEED(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start_btn(start_btn),
    .ldr_sensors(ldr_sensors), .leds_r(leds_r), .score(score),
    .misses(misses), .hit_pulse(hit_pulse), .busy(busy), .game_over(game_over)
  );

  // Returns on the first negedge of an ACTIVE window
  task automatic wait_window(output logic [3:0] v, output bit ok);
    ok = 1'b0;
    v  = 4'b0000;
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b1 && $onehot(leds_r)) begin
        ok = 1'b1;
        v  = leds_r;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Counts negedges (from the current one) with leds_r == v; notes any hit_pulse incl. the exit negedge
  task automatic run_out(input logic [3:0] v, output int len, output bit h);
    len = 0;
    h   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (hit_pulse === 1'b1) h = 1'b1;
      if (leds_r !== v) break;
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b0 && game_over === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    repeat (3) @(negedge clk);
    start_btn = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; tick = 1'b1; start_btn = 1'b0; ldr_sensors = 4'hF;
    repeat (3) @(negedge clk);
    checks++; if (leds_r !== 4'hF) begin errors++; $display("FAIL reset_leds: got %b expected 1111", leds_r); end
    checks++; if (score !== 2'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
    checks++; if (misses !== 2'd0) begin errors++; $display("FAIL reset_misses: got %0d expected 0", misses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b expected 0", game_over); end
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL reset_hit_pulse: got %b expected 0", hit_pulse); end
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (leds_r !== 4'hF || score !== 2'd0 || misses !== 2'd0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_hold: %0d bad cycles, expected 0", bad); end
  endtask

  task automatic test_no_light();
    logic [3:0] v, prev;
    bit ok, h;
    int len;
    prev = 4'b1000;
    start_btn = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_latency_early: busy %b expected 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_latency: busy %b expected 1", busy); end
    checks++; if (leds_r !== 4'b0000) begin errors++; $display("FAIL gap_leds: got %b expected 0000", leds_r); end
    start_btn = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_window(v, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nl_window_timeout: round %0d", r); end
      checks++; if (v === prev) begin errors++; $display("FAIL nl_repeat: round %0d target %b equals previous %b", r, v, prev); end
      run_out(v, len, h);
      checks++; if (len !== 8) begin errors++; $display("FAIL nl_window_len: round %0d got %0d expected 8", r, len); end
      checks++; if (misses !== 2'(r + 1)) begin errors++; $display("FAIL nl_misses: round %0d got %0d expected %0d", r, misses, r + 1); end
      if (r < 2) begin
        checks++; if (leds_r !== 4'b0000) begin errors++; $display("FAIL nl_gap_leds: got %b expected 0000", leds_r); end
      end
      prev = v;
    end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL nl_game_over: got %b expected 1", game_over); end
    checks++; if (leds_r !== 4'hF) begin errors++; $display("FAIL nl_over_leds: got %b expected 1111", leds_r); end
    checks++; if (score !== 2'd0) begin errors++; $display("FAIL nl_score: got %0d expected 0", score); end
    len = 0;
    for (int i = 0; i < 50 && game_over === 1'b1; i++) begin
      len++;
      @(negedge clk);
    end
    checks++; if (len !== 4) begin errors++; $display("FAIL nl_over_len: got %0d expected 4", len); end
    checks++; if (busy !== 1'b0 || leds_r !== 4'hF) begin errors++; $display("FAIL nl_idle: busy %b leds %b expected 0/1111", busy, leds_r); end
    checks++; if (misses !== 2'd3) begin errors++; $display("FAIL nl_misses_hold: got %0d expected 3", misses); end
  endtask

  task automatic test_hits();
    logic [3:0] v;
    bit ok;
    repeat (5) @(negedge clk);
    press_start();
    for (int r = 0; r < 3; r++) begin
      wait_window(v, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hit_window_timeout: round %0d", r); end
      ldr_sensors = ~v;
      repeat (3) @(negedge clk);
      checks++; if (hit_pulse !== 1'b0 || leds_r !== v) begin errors++; $display("FAIL hit_early: pulse %b leds %b expected 0/%b", hit_pulse, leds_r, v); end
      @(negedge clk);
      checks++; if (hit_pulse !== 1'b1) begin errors++; $display("FAIL hit_pulse: round %0d got %b expected 1", r, hit_pulse); end
      checks++; if (score !== 2'(r + 1)) begin errors++; $display("FAIL hit_score: round %0d got %0d expected %0d", r, score, r + 1); end
      checks++; if (leds_r !== ((r < 2) ? 4'h0 : 4'hF)) begin errors++; $display("FAIL hit_leds: round %0d got %b", r, leds_r); end
      ldr_sensors = 4'hF;
      @(negedge clk);
      checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL hit_pulse_width: got %b expected 0", hit_pulse); end
    end
    checks++; if (misses !== 2'd0) begin errors++; $display("FAIL hit_misses: got %0d expected 0", misses); end
    wait_idle(ok);
    checks++; if (ok !== 1'b1 || score !== 2'd3) begin errors++; $display("FAIL hit_final: idle %b score %0d expected 1/3", ok, score); end
  endtask

  task automatic test_short_pulse();
    logic [3:0] v;
    bit ok, h;
    int len;
    repeat (5) @(negedge clk);
    press_start();
    wait_window(v, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL short_window_timeout"); end
    ldr_sensors = ~v;
    @(negedge clk);
    ldr_sensors = 4'hF;
    run_out(v, len, h);
    checks++; if (len + 1 !== 8) begin errors++; $display("FAIL short_len: got %0d expected 8", len + 1); end
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL short_hit: got pulse, expected none"); end
    checks++; if (misses !== 2'd1 || score !== 2'd0) begin errors++; $display("FAIL short_count: misses %0d score %0d expected 1/0", misses, score); end
  endtask

  task automatic test_nontarget();
    logic [3:0] v;
    bit ok, h;
    int len;
    wait_window(v, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nontgt_window_timeout"); end
    ldr_sensors = v;
    run_out(v, len, h);
    ldr_sensors = 4'hF;
    checks++; if (len !== 8 || h !== 1'b0) begin errors++; $display("FAIL nontgt_window: len %0d pulse %b expected 8/0", len, h); end
    checks++; if (misses !== 2'd2 || score !== 2'd0) begin errors++; $display("FAIL nontgt_count: misses %0d score %0d expected 2/0", misses, score); end
  endtask

  task automatic test_hit_on_expiry();
    logic [3:0] v;
    bit ok, h;
    int len;
    wait_window(v, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL expiry_window_timeout"); end
    repeat (4) @(negedge clk);
    ldr_sensors = ~v;
    run_out(v, len, h);
    ldr_sensors = 4'hF;
    checks++; if (len !== 4) begin errors++; $display("FAIL expiry_len: got %0d expected 4 remaining", len); end
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL expiry_pulse: got %b expected 1", h); end
    checks++; if (score !== 2'd1 || misses !== 2'd2) begin errors++; $display("FAIL expiry_count: score %0d misses %0d expected 1/2", score, misses); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL expiry_over: got %b expected 1", game_over); end
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL expiry_idle_timeout"); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] v;
    bit ok;
    repeat (5) @(negedge clk);
    press_start();
    wait_window(v, ok);
    ldr_sensors = ~v;
    repeat (4) @(negedge clk);
    ldr_sensors = 4'hF;
    checks++; if (score !== 2'd1) begin errors++; $display("FAIL midrst_pre_score: got %0d expected 1", score); end
    wait_window(v, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL midrst_window_timeout"); end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (leds_r !== 4'hF || busy !== 1'b0) begin errors++; $display("FAIL midrst_async: leds %b busy %b expected 1111/0", leds_r, busy); end
    checks++; if (score !== 2'd0 || misses !== 2'd0) begin errors++; $display("FAIL midrst_counts: score %0d misses %0d expected 0/0", score, misses); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0 || leds_r !== 4'hF || score !== 2'd0) begin errors++; $display("FAIL midrst_idle: busy %b leds %b score %0d", busy, leds_r, score); end
  endtask

  task automatic test_start_ignored();
    logic [3:0] v;
    bit ok, h;
    int len, bad;
    press_start();
    for (int i = 0; i < 10 && busy !== 1'b1; i++) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_start_timeout: busy %b", busy); end
    start_btn = 1'b1;
    repeat (2) @(negedge clk);
    start_btn = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_window(v, ok);
      run_out(v, len, h);
      checks++; if (ok !== 1'b1 || len !== 8) begin errors++; $display("FAIL ign_window: round %0d ok %b len %0d expected 1/8", r, ok, len); end
    end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL ign_over: got %b expected 1", game_over); end
    start_btn = 1'b1;
    repeat (2) @(negedge clk);
    start_btn = 1'b0;
    wait_idle(ok);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    checks++; if (ok !== 1'b1 || bad !== 0) begin errors++; $display("FAIL ign_restart: idle %b busy cycles %0d expected 1/0", ok, bad); end
    checks++; if (misses !== 2'd3 || score !== 2'd0) begin errors++; $display("FAIL ign_counts: misses %0d score %0d expected 3/0", misses, score); end
  endtask

  initial begin
    test_reset();
    test_no_light();
    test_hits();
    test_short_pulse();
    test_nontarget();
    test_hit_on_expiry();
    test_reset_mid();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
